// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the signed BCD-to-binary converter:
//   - state_e      : converter FSM states (IDLE, WORK, FINISH, DONE)
//   - BCD_DIGITS   : number of BCD input digits (hundreds, tens, ones)
//   - BIN_W        : width of the signed two's-complement result
//   - MAG_W        : width of the unsigned magnitude register
//   - MAX_POS      : largest positive magnitude representable in BIN_W bits
//   - MAX_NEG_MAG  : largest negative magnitude representable in BIN_W bits
//   - any_digit_invalid() : 1 when any packed BCD digit is above 9
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WORK   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int BCD_DIGITS  = 3;
    localparam int BIN_W       = 8;
    localparam int MAG_W       = 10;
    localparam int MAX_POS     = 127;
    localparam int MAX_NEG_MAG = 128;

    // Digits are packed most significant first: {hundreds, tens, ones}.
    function automatic logic any_digit_invalid(input logic [4*BCD_DIGITS-1:0] digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (digits[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational correction for one BCD digit after a right shift in the
// reverse double-dabble algorithm: a digit of 8 or more had a "tens half"
// (value 10 -> 5 after halving) shifted in from the digit above, so it is
// brought back into range by subtracting 3.
// Ports:
//   digit_in  [3:0] : digit after the shift
//   digit_out [3:0] : digit_in - 3 when digit_in >= 8, otherwise digit_in
// -----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        if (digit_in >= 4'd8) begin
            digit_out = digit_in - 4'd3;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
// Sequential signed 3-digit BCD to 8-bit two's-complement converter using
// the reverse double-dabble (shift right / subtract 3) algorithm, one bit
// per clock. A conversion accepted on one rising edge presents its result
// 11 edges later (ITER shift cycles plus one FINISH cycle).
//
// Build option:
//   BCD_TO_BIN_SATURATE_EN defined   : overflowing results clamp to 0x7F/0x80
//   BCD_TO_BIN_SATURATE_EN undefined : overflowing results wrap to the low
//                                      8 bits of the signed magnitude
//   overflow is reported in both builds.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : convert the current inputs (accepted in IDLE or DONE only)
//   sign       : 1 = negative value
//   hundreds   : BCD hundreds digit
//   tens       : BCD tens digit
//   ones       : BCD ones digit
//   binary     : signed two's-complement result (valid while data_ready)
//   busy       : conversion in progress (WORK or FINISH)
//   data_ready : result valid (DONE)
//   overflow   : magnitude does not fit a signed 8-bit value
//   digit_err  : a latched digit was above 9; binary forced to 0
// -----------------------------------------------------------------------------
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int ITER = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic [BIN_W-1:0] binary,
    output logic             busy,
    output logic             data_ready,
    output logic             overflow,
    output logic             digit_err
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(ITER + 1);

    state_e             state_q,     state_d;
    logic [BCD_W-1:0]   bcd_q,       bcd_d;
    logic [MAG_W-1:0]   mag_q,       mag_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               sign_q,      sign_d;
    logic               err_pend_q,  err_pend_d;
    logic [BIN_W-1:0]   binary_q,    binary_d;
    logic               overflow_q,  overflow_d;
    logic               digit_err_q, digit_err_d;

    // -------------------------------------------------------------------------
    // One reverse double-dabble step: shift right, then fix each digit.
    // -------------------------------------------------------------------------
    logic [BCD_W-1:0] bcd_shift;
    logic [BCD_W-1:0] bcd_adj;

    assign bcd_shift = bcd_q >> 1;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_shift[4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    // -------------------------------------------------------------------------
    // Result formation from the final magnitude (used on FINISH -> DONE).
    // -------------------------------------------------------------------------
    logic [MAG_W-1:0] mag_signed;
    logic             res_ovf;
    logic [BIN_W-1:0] res_bin;

    always_comb begin
        // Two's-complement negate in the wider magnitude width; the low
        // BIN_W bits are the wrapped result.
        mag_signed = sign_q ? (MAG_W'(0) - mag_q) : mag_q;

        if (sign_q) begin
            res_ovf = (mag_q > MAG_W'(MAX_NEG_MAG));
        end else begin
            res_ovf = (mag_q > MAG_W'(MAX_POS));
        end

`ifdef BCD_TO_BIN_SATURATE_EN
        if (res_ovf) begin
            res_bin = sign_q ? BIN_W'(-MAX_NEG_MAG) : BIN_W'(MAX_POS);
        end else begin
            res_bin = mag_signed[BIN_W-1:0];
        end
`else
        res_bin = mag_signed[BIN_W-1:0];
`endif
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        bcd_d       = bcd_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        err_pend_d  = err_pend_q;
        binary_d    = binary_q;
        overflow_d  = overflow_q;
        digit_err_d = digit_err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    bcd_d      = {hundreds, tens, ones};
                    sign_d     = sign;
                    err_pend_d = any_digit_invalid({hundreds, tens, ones});
                    mag_d      = '0;
                    cnt_d      = CNT_W'(ITER);
                    state_d    = WORK;
                end
            end

            WORK: begin
                bcd_d = bcd_adj;
                mag_d = {bcd_q[0], mag_q[MAG_W-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                // Invalid digits make the shifted magnitude meaningless, so
                // the result is forced to a clean zero with no overflow.
                if (err_pend_q) begin
                    binary_d    = '0;
                    overflow_d  = 1'b0;
                    digit_err_d = 1'b1;
                end else begin
                    binary_d    = res_bin;
                    overflow_d  = res_ovf;
                    digit_err_d = 1'b0;
                end
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            err_pend_q  <= 1'b0;
            binary_q    <= '0;
            overflow_q  <= 1'b0;
            digit_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            err_pend_q  <= err_pend_d;
            binary_q    <= binary_d;
            overflow_q  <= overflow_d;
            digit_err_q <= digit_err_d;
        end
    end

    assign binary     = binary_q;
    assign overflow   = overflow_q;
    assign digit_err  = digit_err_q;
    assign busy       = (state_q == WORK) || (state_q == FINISH);
    assign data_ready = (state_q == DONE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin
// Self-checking bench for bcd_to_bin: directed corner cases plus randomized
// conversions compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] binary;
    logic       busy;
    logic       data_ready;
    logic       overflow;
    logic       digit_err;

    int total;
    int bad;

    bcd_to_bin #(.ITER(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sign       (sign),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .binary     (binary),
        .busy       (busy),
        .data_ready (data_ready),
        .overflow   (overflow),
        .digit_err  (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {digit_err, overflow, binary}.
    function automatic logic [9:0] model(input logic s, input logic [3:0] h,
                                         input logic [3:0] t, input logic [3:0] o);
        int   mag;
        int   val;
        logic ovf;
        logic [7:0] res;
        if (h > 9 || t > 9 || o > 9) begin
            return {1'b1, 1'b0, 8'h00};
        end
        mag = 100 * h + 10 * t + o;
        ovf = s ? (mag > 128) : (mag > 127);
        val = s ? -mag : mag;
        res = val[7:0];
`ifdef BCD_TO_BIN_SATURATE_EN
        if (ovf) res = s ? 8'h80 : 8'h7F;
`endif
        return {1'b0, ovf, res};
    endfunction

    // Runs one conversion from the current cycle (called #1 after an edge).
    // ign > 0: pulse start with different digits so it is sampled at WORK
    // edge ign; that pulse must be ignored.
    task automatic run_conv(input string tag, input logic s, input logic [3:0] h,
                            input logic [3:0] t, input logic [3:0] o, input int ign);
        logic [9:0] exp;
        exp      = model(s, h, t, o);
        sign     = s;
        hundreds = h;
        tens     = t;
        ones     = o;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " accept"}, {30'd0, busy, data_ready}, 32'b10);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s edge%0d busy/ready", tag, k),
                  {30'd0, busy, data_ready}, (k < 11) ? 32'b10 : 32'b01);
            if (ign > 0 && k == ign - 1) begin
                start    = 1'b1;
                sign     = ~s;
                hundreds = 4'd0;
                tens     = 4'd4;
                ones     = 4'd2;
            end
            if (ign > 0 && k == ign) begin
                start = 1'b0;
            end
        end
        check({tag, " binary"},    {24'd0, binary},  {24'd0, exp[7:0]});
        check({tag, " overflow"},  {31'd0, overflow}, {31'd0, exp[8]});
        check({tag, " digit_err"}, {31'd0, digit_err}, {31'd0, exp[9]});
    endtask

    initial begin
        logic       rs;
        logic [3:0] rh, rt, ro;
        logic [7:0] held_bin;

        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sign     = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {20'd0, binary, busy, data_ready, overflow, digit_err}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle after reset", {30'd0, busy, data_ready}, 32'd0);

        // Directed corner cases.
        run_conv("pos127",   1'b0, 4'd1, 4'd2, 4'd7, 0);
        run_conv("neg128",   1'b1, 4'd1, 4'd2, 4'd8, 0);
        run_conv("neg5",     1'b1, 4'd0, 4'd0, 4'd5, 0);
        run_conv("pos999",   1'b0, 4'd9, 4'd9, 4'd9, 0);
        run_conv("pos128",   1'b0, 4'd1, 4'd2, 4'd8, 0);
        run_conv("neg129",   1'b1, 4'd1, 4'd2, 4'd9, 0);
        run_conv("negzero",  1'b1, 4'd0, 4'd0, 4'd0, 0);
        run_conv("digerr",   1'b0, 4'd0, 4'hA, 4'd3, 0);
        run_conv("neg999",   1'b1, 4'd9, 4'd9, 4'd9, 0);
        run_conv("ignstart", 1'b0, 4'd0, 4'd8, 4'd5, 4);

        // Result holds in DONE while start stays low.
        held_bin = binary;
        repeat (4) @(posedge clk);
        #1;
        check("hold binary", {24'd0, binary}, 32'd85);
        check("hold ready",  {31'd0, data_ready}, 32'd1);
        check("hold same",   {24'd0, binary}, {24'd0, held_bin});

        // Reset in the middle of WORK aborts the conversion.
        sign     = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd9;
        ones     = 4'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort outputs", {20'd0, binary, busy, data_ready, overflow, digit_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-abort idle %0d", k), {30'd0, busy, data_ready}, 32'd0);
        end

        // Randomized conversions, mostly valid digits with occasional bad ones.
        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            rh = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            rt = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            ro = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            if (n % 5 == 0) rh = 4'd1;
            run_conv($sformatf("rand%0d", n), rs, rh, rt, ro, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
